// File: rtl/uds_tile_packer.sv
// Input stage of the upsample/downsample engine: packs ROWS row beats into a
// tile held in a two-entry buffer, then sequences the engine's load/compute strobes.
module uds_tile_packer #(
    parameter int ITEMS = 8,
    parameter int DW    = 32,
    parameter int ROWS  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ITEMS*DW-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [1:0]                cfg_function_mode,
    input  logic [1:0]                cfg_scale_factor,
    output logic [ROWS*ITEMS*DW-1:0]  idata,
    output logic                      idata_valid,
    output logic                      active,
    output logic [1:0]                function_mode,
    output logic [1:0]                scale_factor,
    output logic                      err_short,
    output logic [15:0]               tile_count,
    output logic [1:0]                dbg_state
);

    localparam int BW  = ITEMS * DW;
    localparam int TW  = ROWS * BW;
    localparam int BCW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [BCW-1:0] BC_LAST = BCW'(ROWS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
    // in_ready depends only on registered state, never on in_valid.

    logic [ROWS-1:0][BW-1:0] buf_q [2];
    logic [1:0]              tag_mode_q [2];
    logic [1:0]              tag_scale_q [2];

    logic [1:0]     full_q, full_d;
    logic           wp_q, wp_d;
    logic           rp_q, rp_d;
    logic [BCW-1:0] bc_q, bc_d;
    logic [1:0]     state_q, state_d;
    logic [TW-1:0]  idata_q;
    logic [1:0]     fmode_q;
    logic [1:0]     scale_q;
    logic           err_q;
    logic [15:0]    cnt_q;

    logic fire;
    logic close;
    logic issue;

    assign in_ready = !full_q[wp_q];
    assign fire     = in_valid && in_ready;
    assign close    = fire && (in_last || (bc_q == BC_LAST));
    assign issue    = (state_q == S_IDLE) && full_q[rp_q];

    always_comb begin
        full_d = full_q;
        if (close) full_d[wp_q] = 1'b1;
        // close needs !full[wp] and issue needs full[rp], so they never target one buffer
        if (issue) full_d[rp_q] = 1'b0;
        wp_d = wp_q ^ close;
        rp_d = rp_q ^ issue;
        if (close)     bc_d = '0;
        else if (fire) bc_d = bc_q + 1'b1;
        else           bc_d = bc_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_LOAD;
            S_LOAD:  state_d = S_ACT;
            S_ACT:   state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Tile storage carries no reset: the first beat of every tile rewrites all rows.
    always_ff @(posedge clk) begin
        if (fire) begin
            if (bc_q == '0) begin
                for (int r = 0; r < ROWS; r++) begin
                    buf_q[wp_q][r] <= (r == 0) ? in_data : '0;
                end
                tag_mode_q[wp_q]  <= cfg_function_mode;
                tag_scale_q[wp_q] <= cfg_scale_factor;
            end else begin
                buf_q[wp_q][bc_q] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= '0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            bc_q    <= '0;
            state_q <= S_IDLE;
            idata_q <= '0;
            fmode_q <= '0;
            scale_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            full_q  <= full_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            bc_q    <= bc_d;
            state_q <= state_d;
            if (issue) begin
                idata_q <= buf_q[rp_q];
                fmode_q <= tag_mode_q[rp_q];
                scale_q <= tag_scale_q[rp_q];
            end
            if (fire && in_last && (bc_q != BC_LAST)) err_q <= 1'b1;
            if (state_q == S_GAP) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign idata         = idata_q;
    assign idata_valid   = (state_q == S_LOAD);
    assign active        = (state_q == S_ACT);
    assign function_mode = fmode_q;
    assign scale_factor  = scale_q;
    assign err_short     = err_q;
    assign tile_count    = cnt_q;
    assign dbg_state     = state_q;

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(idata_valid && active));
    a_close_issue_distinct: assert property (@(posedge clk) disable iff (!rst_n)
        (close && issue) |-> (wp_q != rp_q));

endmodule

// File: tb/tb_uds_tile_packer.sv
// Bench for uds_tile_packer: scenario table, hand sequences and random tiles,
// all scored against a tile-level model of the packer.
module tb_uds_tile_packer;

    localparam int ITEMS = 8;
    localparam int DW    = 32;
    localparam int ROWS  = 8;
    localparam int BW    = ITEMS * DW;
    localparam int TW    = ROWS * BW;
    localparam int EW    = TW + 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [BW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [1:0]        cfg_function_mode = '0;
    logic [1:0]        cfg_scale_factor = '0;
    logic [TW-1:0]     idata;
    logic              idata_valid;
    logic              active;
    logic [1:0]        function_mode;
    logic [1:0]        scale_factor;
    logic              err_short;
    logic [15:0]       tile_count;
    logic [1:0]        dbg_state;

    uds_tile_packer #(.ITEMS(ITEMS), .DW(DW), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .cfg_function_mode(cfg_function_mode), .cfg_scale_factor(cfg_scale_factor),
        .idata(idata), .idata_valid(idata_valid), .active(active),
        .function_mode(function_mode), .scale_factor(scale_factor),
        .err_short(err_short), .tile_count(tile_count), .dbg_state(dbg_state)
    );

    // clock/reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // scoreboard: {mode, scale, tile} plus the cycle its load strobe is due
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            valid_cyc_q[$];
    logic [BW-1:0] cur_rows[$];
    logic [1:0]    cur_mode, cur_scale;
    logic          model_err = 1'b0;
    int            issued = 0;
    int            last_exp_valid = -100;
    logic [TW-1:0] held = '0;
    logic [1:0]    held_mode = '0, held_scale = '0;
    logic          act_due = 1'b0;
    logic          saw_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_tile(input string name, input logic [TW-1:0] a, input logic [TW-1:0] e);
        int w;
        vectors++;
        if (a !== e) begin
            miscompares++;
            w = 0;
            for (int i = ROWS*ITEMS-1; i >= 0; i--) if (a[i*DW +: DW] !== e[i*DW +: DW]) w = i;
            $display("FAIL %s word %0d: got %h expected %h (cycle %0d)", name, w,
                     a[w*DW +: DW], e[w*DW +: DW], cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_cyc_q.delete();
        cur_rows.delete();
        model_err = 1'b0;
        issued = 0;
        last_exp_valid = -100;
    endtask

    // a tile closes after ROWS beats or on in_last; missing rows read as zero
    task automatic model_accept(input logic [BW-1:0] d, input logic l,
                                input logic [1:0] m, input logic [1:0] s, input int hs);
        logic [TW-1:0] t;
        int ev;
        if (cur_rows.size() == 0) begin
            cur_mode = m;
            cur_scale = s;
        end
        cur_rows.push_back(d);
        if (l || cur_rows.size() == ROWS) begin
            t = '0;
            for (int i = 0; i < cur_rows.size(); i++) t[i*BW +: BW] = cur_rows[i];
            if (cur_rows.size() < ROWS) model_err = 1'b1;
            ev = hs + 2;
            if (ev < last_exp_valid + 4) ev = last_exp_valid + 4;
            last_exp_valid = ev;
            exp_q.push_back({cur_mode, cur_scale, t});
            exp_cyc_q.push_back(ev);
            cur_rows.delete();
        end
    endtask

    // driver tasks
    task automatic send_beat(input logic [BW-1:0] d, input logic l,
                             input logic [1:0] m, input logic [1:0] s);
        int t;
        int hs;
        @(negedge clk);
        in_data = d;
        in_last = l;
        cfg_function_mode = m;
        cfg_scale_factor = s;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            saw_stall = 1'b1;
            @(negedge clk);
            t++;
        end
        chk("beat_accept_timeout", in_ready, 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        hs = cyc;
        @(posedge clk);
        model_accept(d, l, m, s, hs);
    endtask

    task automatic send_tile(input int nb, input int gap, input logic [1:0] m, input logic [1:0] s,
                             input int chg, input logic [1:0] cm, input logic [1:0] cs,
                             input int base, input bit rnd, input bit lastf);
        logic [BW-1:0] d;
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < ITEMS; j++) d[j*DW +: DW] = rnd ? $urandom : DW'(base + 16*k + j);
            send_beat(d, (k == nb-1) && (nb < ROWS || lastf),
                      (k >= chg) ? cm : m, (k >= chg) ? cs : s);
            if (k < nb-1) repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            in_valid = 1'b0;
            t++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (6) begin @(negedge clk); in_valid = 1'b0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk_tile("rst_idata", idata, '0);
        chk("rst_idata_valid", idata_valid, 0);
        chk("rst_active", active, 0);
        chk("rst_function_mode", function_mode, 0);
        chk("rst_scale_factor", scale_factor, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_tile_count", tile_count, 0);
        rst_n = 1'b1;
    endtask

    // output monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int ec;
        if (!rst_n) begin
            act_due = 1'b0;
            held = '0;
            held_mode = '0;
            held_scale = '0;
        end else if (idata_valid) begin
            chk("active_with_valid", active, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_idata_valid", idata_valid, 0);
            end else begin
                e = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk_tile("idata", idata, e[TW-1:0]);
                chk("function_mode", function_mode, e[EW-1 -: 2]);
                chk("scale_factor", scale_factor, e[TW +: 2]);
                chk("valid_cycle", cyc, ec);
                held = e[TW-1:0];
                held_mode = e[EW-1 -: 2];
                held_scale = e[TW +: 2];
            end
            valid_cyc_q.push_back(cyc);
            issued++;
            act_due = 1'b1;
        end else begin
            chk("active", active, act_due);
            act_due = 1'b0;
            chk_tile("idata_hold", idata, held);
            chk("mode_hold", {function_mode, scale_factor}, {held_mode, held_scale});
        end
    end

    typedef struct {
        int         nb;
        int         gap;
        logic [1:0] mode, scale;
        int         chg;
        logic [1:0] cmode, cscale;
        bit         lastf;
        logic [1:0] emode, escale;
        logic       eerr;
        int         ecnt;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int n0;
        tbl[0] = '{8, 0, 2'b10, 2'b00, 8, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 1};
        tbl[1] = '{8, 1, 2'b10, 2'b00, 4, 2'b00, 2'b01, 1'b1, 2'b10, 2'b00, 1'b0, 2};
        tbl[2] = '{8, 0, 2'b00, 2'b01, 8, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 3};
        tbl[3] = '{3, 0, 2'b01, 2'b11, 8, 2'b00, 2'b00, 1'b0, 2'b01, 2'b11, 1'b1, 4};
        tbl[4] = '{8, 2, 2'b11, 2'b10, 8, 2'b00, 2'b00, 1'b0, 2'b11, 2'b10, 1'b1, 5};

        do_reset();

        for (int i = 0; i < 5; i++) begin
            send_tile(tbl[i].nb, tbl[i].gap, tbl[i].mode, tbl[i].scale, tbl[i].chg,
                      tbl[i].cmode, tbl[i].cscale, (i == 0) ? 0 : 32'h1000 * i, 1'b0, tbl[i].lastf);
            drain();
            chk("tbl_function_mode", function_mode, tbl[i].emode);
            chk("tbl_scale_factor", scale_factor, tbl[i].escale);
            chk("tbl_err_short", err_short, tbl[i].eerr);
            chk("tbl_tile_count", tile_count, tbl[i].ecnt);
            if (i == 0) chk("tile0_word9", idata[9*DW +: DW], 17);
            if (i == 3) chk("short_rows_zero", |idata[TW-1:3*BW], 0);
        end

        // three tiles back to back at full input duty
        saw_stall = 1'b0;
        n0 = valid_cyc_q.size();
        for (int i = 0; i < 3; i++) send_tile(8, 0, 2'(i), 2'(i+1), 8, 0, 0, 0, 1'b1, 1'b0);
        drain();
        chk("cont_no_stall", saw_stall, 0);
        chk("cont_spacing_a", valid_cyc_q[n0+1] - valid_cyc_q[n0], 8);
        chk("cont_spacing_b", valid_cyc_q[n0+2] - valid_cyc_q[n0+1], 8);
        chk("cont_tile_count", tile_count, issued);

        // single-beat tiles outrun the issue side
        saw_stall = 1'b0;
        for (int i = 0; i < 10; i++) send_tile(1, 0, 2'(i), 2'(~i), 8, 0, 0, 0, 1'b1, 1'b0);
        drain();
        chk("single_beat_backpressure", saw_stall, 1);
        chk("single_tile_count", tile_count, issued);

        // random tiles
        for (int i = 0; i < 30; i++) begin
            logic [1:0] m = 2'($urandom_range(0, 3));
            logic [1:0] s = 2'($urandom_range(0, 3));
            send_tile($urandom_range(1, 8), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                      m, s, $urandom_range(0, 9), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      0, 1'b1, 1'(($urandom_range(0, 1))));
        end
        drain();
        chk("rand_tile_count", tile_count, issued);
        chk("rand_err_short", err_short, model_err);

        // reset in the middle of a tile
        for (int k = 0; k < 5; k++) send_beat(BW'($urandom), 1'b0, 2'b01, 2'b01);
        do_reset();
        repeat (12) @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_no_issue", issued, 0);
        send_tile(8, 0, 2'b10, 2'b01, 8, 0, 0, 0, 1'b0, 1'b0);
        drain();
        chk("post_rst_tile_count", tile_count, 1);
        chk("post_rst_word63", idata[63*DW +: DW], 16*7 + 7);
        chk("post_rst_err_short", err_short, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
